// File: rtl/mdio_mgmt.sv
// mdio_mgmt: Clause-22 MDIO management master for three PHY buses.
//
// After reset (or on phy_reset_req) it holds phy_reset_n low for RST_HOLD
// cycles, waits RST_WAIT cycles with the resets released, then accepts
// read/write commands and serialises each one as a 64-bit MDIO frame on
// the selected port.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   phy_reset_req     - one-cycle pulse requesting a new PHY reset sequence
//   cmd_*             - command port (valid/ready), cmd_port selects PHY bus
//   rsp_valid         - one-cycle completion pulse, with rsp_rdata/rsp_err
//   busy              - high whenever the engine is not idle
//   mdc/mdio_o/mdio_t - per-port management pins (mdio_t = 1 releases)
//   mdio_i            - per-port synchronised MDIO input
//   phy_reset_n       - PHY hardware resets, driven together
//
// Handshake: a command transfers on any cycle where cmd_valid and cmd_ready
// are both high; cmd_ready is a pure decode of the IDLE state register, so
// it falls the cycle after an accept and returns only when IDLE is re-entered.
module mdio_mgmt #(
  parameter int CLK_DIV  = 25,
  parameter int RST_HOLD = 1250000,
  parameter int RST_WAIT = 6250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_reset_req,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_port,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  mdc,
  output logic [2:0]  mdio_o,
  output logic [2:0]  mdio_t,
  input  logic [2:0]  mdio_i,
  output logic [2:0]  phy_reset_n
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_RST_WAIT,
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]      rst_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_idx;
  logic [63:0]      frame;     // outgoing bits, MSB is the bit on the wire
  logic [1:0]       port_q;
  logic             read_q;
  logic             pend_q;    // reset request deferred until frame completes
  logic             ta_err_q;
  logic [15:0]      rd_shift;

  logic accept, bit_end, last_bit, hold_done, wait_done;
  logic mdc_hi, sample_now, mdio_sel, released;

  assign accept     = (state == S_IDLE) && cmd_valid;
  assign bit_end    = (div_cnt == DIV_W'(2 * CLK_DIV - 1));
  assign last_bit   = bit_end && (bit_idx == 6'd63);
  assign hold_done  = (rst_cnt == 32'(RST_HOLD - 1));
  assign wait_done  = (rst_cnt == 32'(RST_WAIT - 1));
  assign mdc_hi     = (div_cnt >= DIV_W'(CLK_DIV));
  // The first cycle of the high half is the MDC rising edge.
  assign sample_now = (state == S_SHIFT) && read_q && (div_cnt == DIV_W'(CLK_DIV));
  assign released   = read_q && (bit_idx >= 6'd46);

  always_comb begin
    case (port_q)
      2'd0:    mdio_sel = mdio_i[0];
      2'd1:    mdio_sel = mdio_i[1];
      default: mdio_sel = mdio_i[2];
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_RST_HOLD: begin
        if (!phy_reset_req && hold_done) state_nx = S_RST_WAIT;
      end
      S_RST_WAIT: begin
        if (phy_reset_req)  state_nx = S_RST_HOLD;
        else if (wait_done) state_nx = S_RST_WAIT == S_RST_WAIT ? S_IDLE : S_IDLE;
      end
      S_IDLE: begin
        // An accept wins over a same-cycle reset request; the request is
        // then deferred like one arriving mid-frame.
        if (accept)                    state_nx = (cmd_port == 2'd3) ? S_DONE : S_SHIFT;
        else if (phy_reset_req || pend_q) state_nx = S_RST_HOLD;
      end
      S_SHIFT: begin
        if (last_bit) state_nx = S_DONE;
      end
      S_DONE: begin
        // Go straight to reset so no command can slip in between.
        state_nx = (phy_reset_req || pend_q) ? S_RST_HOLD : S_IDLE;
      end
      default: state_nx = S_RST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RST_HOLD;
      rst_cnt   <= '0;
      div_cnt   <= '0;
      bit_idx   <= '0;
      frame     <= '0;
      port_q    <= '0;
      read_q    <= 1'b0;
      pend_q    <= 1'b0;
      ta_err_q  <= 1'b0;
      rd_shift  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;

      // Restart the reset timers on every state change and on any request.
      if ((state_nx != state) || phy_reset_req) rst_cnt <= '0;
      else                                      rst_cnt <= rst_cnt + 32'd1;

      if (state_nx == S_RST_HOLD) pend_q <= 1'b0;
      else if (phy_reset_req)     pend_q <= 1'b1;

      if (accept) begin
        port_q   <= cmd_port;
        read_q   <= cmd_read;
        frame    <= {32'hFFFF_FFFF, 2'b01,
                     cmd_read ? 2'b10 : 2'b01,
                     cmd_phyad, cmd_regad,
                     cmd_read ? 2'b11 : 2'b10,
                     cmd_read ? 16'h0000 : cmd_wdata};
        div_cnt  <= '0;
        bit_idx  <= '0;
        ta_err_q <= 1'b0;
        rd_shift <= '0;
        if (cmd_port == 2'd3) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end else if (state == S_SHIFT) begin
        if (bit_end) begin
          div_cnt <= '0;
          bit_idx <= bit_idx + 6'd1;
          frame   <= {frame[62:0], 1'b0};
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end

        if (sample_now) begin
          if (bit_idx == 6'd47)      ta_err_q <= mdio_sel;
          else if (bit_idx >= 6'd48) rd_shift <= {rd_shift[14:0], mdio_sel};
        end

        // Bit 63 was sampled mid-bit, so rd_shift is complete here.
        if (last_bit) begin
          rsp_rdata <= read_q ? rd_shift : 16'h0000;
          rsp_err   <= read_q && ta_err_q;
        end
      end
    end
  end

  // Pin decode: only the selected port ever toggles or drives.
  always_comb begin
    mdc    = '0;
    mdio_o = '0;
    mdio_t = '1;
    if (state == S_SHIFT) begin
      for (int i = 0; i < 3; i++) begin
        if (port_q == 2'(i)) begin
          mdc[i]    = mdc_hi;
          mdio_o[i] = frame[63] && !released;
          mdio_t[i] = released;
        end
      end
    end
  end

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rsp_valid   = (state == S_DONE);
  assign phy_reset_n = (state == S_RST_HOLD) ? 3'b000 : 3'b111;

endmodule

// File: tb/tb_mdio_mgmt.sv
// tb_mdio_mgmt: directed bench for mdio_mgmt with a small PHY model that
// decodes the selected port's frame on MDC rising edges and drives read
// turnaround/data bits after each MDC falling edge.
module tb_mdio_mgmt;

  localparam int CLK_DIV  = 2;
  localparam int RST_HOLD = 10;
  localparam int RST_WAIT = 5;
  localparam int FRAME_LAT = 128 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phy_reset_req = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_port = '0;
  logic        cmd_read = 1'b0;
  logic [4:0]  cmd_phyad = '0;
  logic [4:0]  cmd_regad = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [2:0]  mdc, mdio_o, mdio_t, phy_reset_n;
  logic [2:0]  mdio_i = 3'b111;

  mdio_mgmt #(.CLK_DIV(CLK_DIV), .RST_HOLD(RST_HOLD), .RST_WAIT(RST_WAIT)) dut (
    .clk(clk), .rst(rst), .phy_reset_req(phy_reset_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_port(cmd_port),
    .cmd_read(cmd_read), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_t(mdio_t), .mdio_i(mdio_i), .phy_reset_n(phy_reset_n)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  logic        phy_ta;
  logic [15:0] phy_data;
  logic [63:0] obs_o, obs_t;
  int          rises, other_mdc, lat;
  logic        got_rsp, err_d;
  logic [15:0] rdata_d;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic phy_bit(input int k);
    if (k == 47) return phy_ta;
    if (k >= 48 && k <= 63) return phy_data[63-k];
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] port, input logic rd, input logic [4:0] phyad,
                      input logic [4:0] regad, input logic [15:0] wdata);
    @(negedge clk);
    check("ready_before_send", {63'd0, cmd_ready}, 64'd1);
    mdio_i    = 3'b111;
    cmd_port  = port;
    cmd_read  = rd;
    cmd_phyad = phyad;
    cmd_regad = regad;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Watches the bus cycle by cycle after an accept; p = 3 means no port is
  // expected to be active. Optionally pulses phy_reset_req at the start of
  // bit req_bit.
  task automatic watch(input int p, input int budget, input int req_bit);
    logic [2:0] prev_mdc;
    int r;
    obs_o = '0; obs_t = '0; r = 0; other_mdc = 0; lat = 0; got_rsp = 1'b0;
    prev_mdc = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      phy_reset_req = 1'b0;
      for (int q = 0; q < 3; q++) if (q != p && mdc[q]) other_mdc++;
      if (p < 3) begin
        if (mdc[p] && !prev_mdc[p]) begin
          if (r < 64) begin
            obs_o[63-r] = mdio_o[p];
            obs_t[63-r] = mdio_t[p];
          end
          r++;
        end
        if (!mdc[p] && prev_mdc[p]) begin
          mdio_i[p] = phy_bit(r);
          if (r == req_bit) phy_reset_req = 1'b1;
        end
      end
      prev_mdc = mdc;
      if (rsp_valid) begin
        got_rsp = 1'b1;
        lat     = c;
        rdata_d = rsp_rdata;
        err_d   = rsp_err;
        break;
      end
    end
    rises = r;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] rn_hist, rdy_hist, t_hist;
    int n;

    // Reset values and reset sequence
    repeat (3) @(negedge clk);
    check("reset_values",
          {25'd0, mdc, mdio_o, mdio_t, phy_reset_n, cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy},
          {25'd0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1});
    rst = 1'b0;
    rn_hist = '0; rdy_hist = '0; t_hist = '0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      rn_hist[i]  = &phy_reset_n;
      rdy_hist[i] = cmd_ready;
      t_hist[i]   = &mdio_t;
    end
    check("rst_seq_phy_reset_n", {48'd0, rn_hist}, 64'h0000_0000_0000_FC00);
    check("rst_seq_cmd_ready", {48'd0, rdy_hist}, 64'h0000_0000_0000_8000);
    check("rst_seq_mdio_t", {48'd0, t_hist}, 64'h0000_0000_0000_FFFF);

    // Write port 1, phyad 1, regad 0, data 0x1140
    exp_q.push_back({32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1140});
    send(2'd1, 1'b0, 5'h01, 5'h00, 16'h1140);
    watch(1, 400, -1);
    check("wr_got_rsp", {63'd0, got_rsp}, 64'd1);
    check("wr_latency", 64'(lat), 64'(FRAME_LAT));
    check("wr_frame", obs_o, exp_q.pop_front());
    check("wr_mdio_t", obs_t, 64'd0);
    check("wr_rises", 64'(rises), 64'd64);
    check("wr_other_mdc", 64'(other_mdc), 64'd0);
    check("wr_rsp", {47'd0, err_d, rdata_d}, {47'd0, 1'b0, 16'h0000});
    @(negedge clk);
    check("wr_rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);

    // Read port 2, phyad 1, regad 2: PHY returns TA=0, data 0x0141
    phy_ta = 1'b0; phy_data = 16'h0141;
    exp_q.push_back({32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h02, 18'd0});
    send(2'd2, 1'b1, 5'h01, 5'h02, 16'hDEAD);
    watch(2, 400, -1);
    check("rd_latency", 64'(lat), 64'(FRAME_LAT));
    check("rd_header", obs_o & 64'hFFFF_FFFF_FFFC_0000, exp_q.pop_front());
    check("rd_mdio_t", obs_t, 64'h0000_0000_0003_FFFF);
    check("rd_other_mdc", 64'(other_mdc), 64'd0);
    check("rd_rsp", {47'd0, err_d, rdata_d}, {47'd0, 1'b0, 16'h0141});
    @(negedge clk);
    check("rd_rdata_held", {48'd0, rsp_rdata}, 64'h0141);

    // Turnaround error: PHY absent, bus floats high
    phy_ta = 1'b1; phy_data = 16'hFFFF;
    send(2'd2, 1'b1, 5'h01, 5'h02, 16'h0000);
    watch(2, 400, -1);
    check("ta_latency", 64'(lat), 64'(FRAME_LAT));
    check("ta_rsp", {47'd0, err_d, rdata_d}, {47'd0, 1'b1, 16'hFFFF});

    // rst mid-frame
    send(2'd1, 1'b0, 5'h03, 5'h04, 16'hA5A5);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_frame_values",
          {25'd0, mdc, mdio_o, mdio_t, phy_reset_n, cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy},
          {25'd0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1});
    rst = 1'b0;
    watch(3, 14, -1);
    check("rst_mid_frame_no_rsp", {63'd0, got_rsp}, 64'd0);
    wait_ready(40, n);
    check("rst_mid_frame_ready", {63'd0, cmd_ready}, 64'd1);

    // Invalid port
    send(2'd3, 1'b0, 5'h01, 5'h00, 16'h1234);
    watch(3, 10, -1);
    check("inv_latency", 64'(lat), 64'd1);
    check("inv_rsp", {47'd0, err_d, rdata_d}, {47'd0, 1'b1, 16'h0000});
    check("inv_no_mdc", 64'(other_mdc), 64'd0);

    // Reset request during bit 20 of a write on port 0
    send(2'd0, 1'b0, 5'h02, 5'h1F, 16'h8001);
    watch(0, 400, 20);
    check("req_latency", 64'(lat), 64'(FRAME_LAT));
    check("req_rsp", {47'd0, err_d, rdata_d}, {47'd0, 1'b0, 16'h0000});
    cmd_valid = 1'b1;  // offered command must not be taken before the reset
    @(negedge clk);
    check("req_reset_after_done", {58'd0, phy_reset_n, cmd_ready, busy, rsp_valid},
          {58'd0, 3'b000, 1'b0, 1'b1, 1'b0});
    cmd_valid = 1'b0;
    wait_ready(40, n);
    check("req_reset_duration", 64'(n), 64'(RST_HOLD + RST_WAIT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
